bsk_prm_master: RTL
===================

BSK_PRM_MASTER -- requirements
Module: bsk_prm_master

Interface
REQ-001 Parameter CS, 4'b0111, chip-select code driven on oCS.
REQ-002 Parameter STROBE_LEN, 4, number of clocks iWr/iRd strobe is held low (range 1..15).
REQ-003 Parameter PASSWORD, 8'hA6, expected readback of address 3 bits [15:8].
REQ-004 iClk  in  1  system clock; all state changes on rising edge.
REQ-005 iRes  in  1  asynchronous reset, active low.
REQ-006 iStart  in  1  request one update sequence; sampled only in IDLE.
REQ-007 iCom  in  16  command word to transfer.
REQ-008 iComInd  in  16  command-indication word (active 1).
REQ-009 iEnable  in  1  1 = write enable code 8'hE1 to control, 0 = write 8'h00.
REQ-010 oBusy  out  1  high while a sequence is in progress.
REQ-011 oDone  out  1  one-clock pulse at sequence end.
REQ-012 oErr  out  1  readback failure flag of the last sequence.
REQ-013 oErrCode  out  2  00 none, 01 command mismatch, 10 password mismatch, 11 enable-flag mismatch.
REQ-014 oA  out  2  bus address.
REQ-015 oCS  out  4  chip select; CS during an access, 4'b0000 otherwise.
REQ-016 oWr  out  1  write strobe, active low.
REQ-017 oRd  out  1  read strobe, active low.
REQ-018 bD  inout  16  bus data; driven only during write accesses, else high-Z.

Function
REQ-019 iStart high in IDLE SHALL latch iCom, iComInd, iEnable and start the sequence on the next clock; iStart while busy SHALL be ignored.
REQ-020 Sequence order fixed: W0 (A=0), W1 (A=1), W2 (A=2), W3 (A=3), R1 (A=1), R3 (A=3), DONE, IDLE.
REQ-021 Each access SHALL be SETUP 1 clock (A, CS, data valid, strobes high), STROBE STROBE_LEN clocks (strobe low), HOLD 1 clock (strobe high, A/CS/data held).
REQ-022 W0 data = {com[7:4], ~com[7:4], com[3:0], ~com[3:0]}; W1 data = {com[15:12], ~com[15:12], com[11:8], ~com[11:8]}.
REQ-023 W2 data = iComInd latched; W3 data = {8'h00, iEnable ? 8'hE1 : 8'h00}.
REQ-024 Reads SHALL sample bD on the last STROBE clock.
REQ-025 R1 mismatch with latched iCom SHALL set code 01; R3 bits [15:8] != PASSWORD SHALL set code 10; R3 bit0 != latched iEnable SHALL set code 11.
REQ-026 Only the first error of a sequence SHALL be recorded; the sequence SHALL always run to DONE.
REQ-027 oErr/oErrCode SHALL be cleared when a new sequence starts and updated by the end of DONE.
REQ-028 oDone SHALL be high exactly one clock, 6*(STROBE_LEN+2)+1 clocks after the edge sampling iStart (37 at default).
REQ-029 oBusy SHALL be high from the clock after iStart through the DONE clock.
REQ-030 oWr and oRd SHALL never be low simultaneously; bD SHALL be high-Z whenever oRd is low.

Reset
REQ-031 iRes low SHALL immediately force IDLE, oWr=1, oRd=1, oCS=0, oA=0, bD high-Z, oBusy=0, oDone=0, oErr=0, oErrCode=00, latched words 0.
REQ-032 Reset mid-access SHALL abort with no further strobes; no oDone for the aborted sequence.

Structure
REQ-033 Shared package bsk_pkg SHALL hold PASSWORD, ENABLE (8'hE1), the address constants and the error-code enum; the state enum stays local.
REQ-034 Single-access timing (SETUP/STROBE/HOLD counter, strobe and bus drive) SHALL be sub-module bsk_bus_cycle; the sequencer issues start/dir/addr/data and gets done/rdata.

Verification
REQ-035 iCom=16'h1234, iEnable=1 -> bD W0=16'h3C4B, W1=16'h1E2D, W3=16'h00E1; oDone on clock 37, oErr=0.
REQ-036 PRM model returns com=16'h1235 at R1 -> oErr=1, oErrCode=01.
REQ-037 PRM model returns password 8'hA5 -> oErrCode=10; with an R1 mismatch in the same sequence -> oErrCode=01.
REQ-038 iStart pulsed again at clock 10 of a sequence -> ignored; exactly one oDone.
REQ-039 iRes low during the W2 STROBE phase -> oWr=1 and bD=Z immediately; no oDone; next iStart runs a full correct sequence.
REQ-040 STROBE_LEN=1 -> every strobe low for one clock; oDone on clock 19.

Source files
------------

// File: rtl/bsk_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bsk_pkg : shared constants, error codes and data helper for PRM    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package bsk_pkg;

   localparam logic [7:0] PASSWORD = 8'hA6;
   localparam logic [7:0] ENABLE   = 8'hE1;

   localparam logic [1:0] ADDR_COM_LO = 2'd0;
   localparam logic [1:0] ADDR_COM_HI = 2'd1;
   localparam logic [1:0] ADDR_IND    = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   typedef enum logic [1:0] {
      ERR_NONE = 2'b00,
      ERR_COM  = 2'b01,
      ERR_PWD  = 2'b10,
      ERR_ENA  = 2'b11
   } err_code_t;

   // Each nibble is followed by its complement so the PRM can detect corruption.
   function automatic logic [15:0] f_pair(input logic [7:0] b);
      return {b[7:4], ~b[7:4], b[3:0], ~b[3:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/bsk_prm_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bsk_prm_master_if : host control and PRM bus strobes               |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface bsk_prm_master_if;
   logic        iStart;
   logic [15:0] iCom;
   logic [15:0] iComInd;
   logic        iEnable;
   logic        oBusy;
   logic        oDone;
   logic        oErr;
   logic [1:0]  oErrCode;
   logic [1:0]  oA;
   logic [3:0]  oCS;
   logic        oWr;
   logic        oRd;

   modport master (
      input  iStart, iCom, iComInd, iEnable,
      output oBusy, oDone, oErr, oErrCode, oA, oCS, oWr, oRd
   );

   modport slave (
      output iStart, iCom, iComInd, iEnable,
      input  oBusy, oDone, oErr, oErrCode, oA, oCS, oWr, oRd
   );
endinterface
`default_nettype wire

// File: rtl/bsk_bus_cycle.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bsk_bus_cycle : one SETUP / STROBE / HOLD access on the PRM bus    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module bsk_bus_cycle #(
   parameter logic [3:0] CS         = 4'b0111,
   parameter int         STROBE_LEN = 4
) (
   input  logic        iClk,
   input  logic        iRes,
   input  logic        i_start,
   input  logic        i_dir,
   input  logic [1:0]  i_addr,
   input  logic [15:0] i_wdata,
   input  logic [15:0] i_bd,
   output logic        o_done,
   output logic [15:0] o_rdata,
   output logic [1:0]  o_a,
   output logic [3:0]  o_cs,
   output logic        o_wr,
   output logic        o_rd,
   output logic        o_drive,
   output logic [15:0] o_wdata
);

   typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

   localparam logic [3:0] c_LAST = 4'(STROBE_LEN - 1);

   phase_t      r_phase, w_phase_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic        r_dir;
   logic [1:0]  r_addr;
   logic [15:0] r_wdata, r_rdata;
   logic        w_load, w_active;

   // A new access may follow HOLD directly so back-to-back accesses have no gap.
   assign w_load   = i_start && (r_phase == PH_IDLE || r_phase == PH_HOLD);
   assign w_active = (r_phase != PH_IDLE);

   always_ff @(posedge iClk or negedge iRes) begin
      if (!iRes) begin
         r_phase <= PH_IDLE;
         r_cnt   <= 4'd0;
         r_dir   <= 1'b0;
         r_addr  <= 2'd0;
         r_wdata <= 16'h0000;
         r_rdata <= 16'h0000;
      end else begin
         r_phase <= w_phase_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_load) begin
            r_dir   <= i_dir;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
         end
         if (r_phase == PH_STROBE && r_cnt == c_LAST && r_dir)
            r_rdata <= i_bd;
      end
   end

   always_comb begin
      w_phase_nxt = r_phase;
      w_cnt_nxt   = r_cnt;
      case (r_phase)
         PH_IDLE:   if (i_start) w_phase_nxt = PH_SETUP;
         PH_SETUP: begin
            w_phase_nxt = PH_STROBE;
            w_cnt_nxt   = 4'd0;
         end
         PH_STROBE: begin
            if (r_cnt == c_LAST) w_phase_nxt = PH_HOLD;
            else                 w_cnt_nxt   = r_cnt + 4'd1;
         end
         PH_HOLD:   w_phase_nxt = i_start ? PH_SETUP : PH_IDLE;
         default:   w_phase_nxt = PH_IDLE;
      endcase
   end

   assign o_done  = (r_phase == PH_HOLD);
   assign o_rdata = r_rdata;
   assign o_a     = w_active ? r_addr : 2'd0;
   assign o_cs    = w_active ? CS : 4'b0000;
   assign o_wr    = !(r_phase == PH_STROBE && !r_dir);
   assign o_rd    = !(r_phase == PH_STROBE && r_dir);
   assign o_drive = w_active && !r_dir;
   assign o_wdata = r_wdata;

endmodule
`default_nettype wire

// File: rtl/bsk_prm_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bsk_prm_master : writes command/indication/control to PRM, reads   |
// | back command and password/enable word, reports first mismatch      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module bsk_prm_master
   import bsk_pkg::*;
#(
   parameter logic [3:0] CS         = 4'b0111,
   parameter int         STROBE_LEN = 4,
   parameter logic [7:0] PASSWORD   = bsk_pkg::PASSWORD
) (
   input  logic               iClk,
   input  logic               iRes,
   bsk_prm_master_if.master   bus,
   inout  wire  [15:0]        bD
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_idx, w_idx_nxt, w_bc_idx;
   err_code_t   r_code, w_code_nxt;
   logic [15:0] r_com, r_ind;
   logic        r_ena;
   logic        w_start_seq, w_bc_start, w_bc_done, w_bc_dir, w_drive;
   logic [1:0]  w_bc_addr;
   logic [15:0] w_bc_wdata, w_rdata, w_bus_wdata;

   assign w_start_seq = (r_state == ST_IDLE) && bus.iStart;

   always_ff @(posedge iClk or negedge iRes) begin
      if (!iRes) begin
         r_state <= ST_IDLE;
         r_idx   <= 3'd0;
         r_code  <= ERR_NONE;
         r_com   <= 16'h0000;
         r_ind   <= 16'h0000;
         r_ena   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_code  <= w_code_nxt;
         if (w_start_seq) begin
            r_com <= bus.iCom;
            r_ind <= bus.iComInd;
            r_ena <= bus.iEnable;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_code_nxt  = r_code;
      w_bc_start  = 1'b0;
      w_bc_idx    = r_idx + 3'd1;
      case (r_state)
         ST_IDLE: if (bus.iStart) begin
            w_state_nxt = ST_RUN;
            w_idx_nxt   = 3'd0;
            w_bc_start  = 1'b1;
            w_bc_idx    = 3'd0;
            w_code_nxt  = ERR_NONE;
         end
         ST_RUN: if (w_bc_done) begin
            if (r_idx == 3'd4 && w_rdata != r_com && r_code == ERR_NONE)
               w_code_nxt = ERR_COM;
            if (r_idx == 3'd5) begin
               if (r_code == ERR_NONE) begin
                  if (w_rdata[15:8] != PASSWORD)  w_code_nxt = ERR_PWD;
                  else if (w_rdata[0] != r_ena)   w_code_nxt = ERR_ENA;
               end
               w_state_nxt = ST_DONE;
            end else begin
               w_bc_start = 1'b1;
               w_idx_nxt  = r_idx + 3'd1;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // W0 is issued on the start edge itself, before the command is latched.
   always_comb begin
      w_bc_dir   = 1'b0;
      w_bc_addr  = ADDR_CTRL;
      w_bc_wdata = 16'h0000;
      case (w_bc_idx)
         3'd0: begin w_bc_addr = ADDR_COM_LO; w_bc_wdata = f_pair(bus.iCom[7:0]); end
         3'd1: begin w_bc_addr = ADDR_COM_HI; w_bc_wdata = f_pair(r_com[15:8]); end
         3'd2: begin w_bc_addr = ADDR_IND;    w_bc_wdata = r_ind; end
         3'd3: begin w_bc_addr = ADDR_CTRL;   w_bc_wdata = {8'h00, r_ena ? ENABLE : 8'h00}; end
         3'd4: begin w_bc_addr = ADDR_COM_HI; w_bc_dir = 1'b1; end
         default: begin w_bc_addr = ADDR_CTRL; w_bc_dir = 1'b1; end
      endcase
   end

   bsk_bus_cycle #(.CS(CS), .STROBE_LEN(STROBE_LEN)) u_bus_cycle (
      .iClk    (iClk),
      .iRes    (iRes),
      .i_start (w_bc_start),
      .i_dir   (w_bc_dir),
      .i_addr  (w_bc_addr),
      .i_wdata (w_bc_wdata),
      .i_bd    (bD),
      .o_done  (w_bc_done),
      .o_rdata (w_rdata),
      .o_a     (bus.oA),
      .o_cs    (bus.oCS),
      .o_wr    (bus.oWr),
      .o_rd    (bus.oRd),
      .o_drive (w_drive),
      .o_wdata (w_bus_wdata)
   );

   assign bD           = w_drive ? w_bus_wdata : 16'hzzzz;
   assign bus.oBusy    = (r_state != ST_IDLE);
   assign bus.oDone    = (r_state == ST_DONE);
   assign bus.oErr     = (r_code != ERR_NONE);
   assign bus.oErrCode = r_code;

endmodule
`default_nettype wire
